// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches: written at fetch, popped at resolution.
// Drives the predictor table update and flushes wrong-path entries on a mispredict.
module branch_resolve_queue #(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      push,
  input  logic [IWIDTH-1:0]         push_index,
  input  logic [HWIDTH-1:0]         push_hist,
  input  logic                      push_taken,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      resolve,
  input  logic                      resolve_taken,
  output logic                      upd_valid,
  output logic [IWIDTH-1:0]         upd_index,
  output logic [HWIDTH-1:0]         upd_hist,
  output logic                      upd_taken,
  output logic                      mispredict,
  output logic                      underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [IWIDTH-1:0] mem_index [DEPTH];
  logic [HWIDTH-1:0] mem_hist  [DEPTH];
  logic              mem_taken [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_inc, wr_ptr_inc;
  logic          do_pop, mis, push_ok;
  logic [CW-1:0] count_nxt;

  always_comb begin
    do_pop     = resolve && (count != '0);
    mis        = do_pop && (mem_taken[rd_ptr] != resolve_taken);
    // A correct pop frees a slot in the same cycle, so a push at full still fits.
    push_ok    = push && !mis && ((count != FULL_CNT) || do_pop);
    rd_ptr_inc = rd_ptr + 1'b1;
    wr_ptr_inc = wr_ptr + 1'b1;
    count_nxt  = count + CW'(push_ok) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset && en && push_ok) begin
      mem_index[wr_ptr] <= push_index;
      mem_hist[wr_ptr]  <= push_hist;
      mem_taken[wr_ptr] <= push_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      upd_valid  <= 1'b0;
      upd_index  <= '0;
      upd_hist   <= '0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      underflow  <= 1'b0;
    end else if (en) begin
      upd_valid  <= do_pop;
      mispredict <= mis;
      if (do_pop) begin
        upd_index <= mem_index[rd_ptr];
        upd_hist  <= mem_hist[rd_ptr];
        upd_taken <= resolve_taken;
        rd_ptr    <= rd_ptr_inc;
      end
      if (resolve && (count == '0))
        underflow <= 1'b1;
      if (mis) begin
        // Everything younger than the mispredicted branch is wrong-path.
        wr_ptr <= rd_ptr_inc;
        count  <= '0;
        empty  <= 1'b1;
        full   <= 1'b0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr_inc;
        count <= count_nxt;
        empty <= (count_nxt == '0);
        full  <= (count_nxt == FULL_CNT);
      end
    end else begin
      upd_valid  <= 1'b0;
      mispredict <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int IWIDTH = 6;
  localparam int HWIDTH = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset, en, push, push_taken, resolve, resolve_taken;
  logic [IWIDTH-1:0] push_index;
  logic [HWIDTH-1:0] push_hist;
  logic full, empty, upd_valid, upd_taken, mispredict, underflow;
  logic [$clog2(DEPTH):0] count;
  logic [IWIDTH-1:0] upd_index;
  logic [HWIDTH-1:0] upd_hist;

  always #5 clk = ~clk;

  branch_resolve_queue #(.IWIDTH(IWIDTH), .HWIDTH(HWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .push(push), .push_index(push_index),
    .push_hist(push_hist), .push_taken(push_taken), .full(full), .empty(empty),
    .count(count), .resolve(resolve), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .mispredict(mispredict), .underflow(underflow)
  );

  typedef struct packed {
    logic [IWIDTH-1:0] idx;
    logic [HWIDTH-1:0] hist;
    logic              taken;
  } ent_t;

  ent_t q[$];
  logic              e_uv, e_mp, e_uf, e_tk;
  logic [IWIDTH-1:0] e_idx;
  logic [HWIDTH-1:0] e_hist;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a resolve pops the oldest entry first; a push then fits if the
  // queue has room after that pop, unless the pop exposed a mispredict.
  task automatic model();
    ent_t e;
    bit   mis;
    if (reset) begin
      q.delete();
      e_uv = 0; e_mp = 0; e_uf = 0; e_tk = 0; e_idx = '0; e_hist = '0;
    end else if (en) begin
      e_uv = 0; e_mp = 0; mis = 0;
      if (resolve) begin
        if (q.size() == 0) e_uf = 1;
        else begin
          e = q.pop_front();
          e_uv = 1; e_idx = e.idx; e_hist = e.hist; e_tk = resolve_taken;
          mis = (e.taken != resolve_taken);
          e_mp = mis;
        end
      end
      if (mis) q.delete();
      else if (push && q.size() < DEPTH) q.push_back('{push_index, push_hist, push_taken});
    end else begin
      e_uv = 0; e_mp = 0;
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("upd_valid", 32'(upd_valid), 32'(e_uv));
    chk("mispredict", 32'(mispredict), 32'(e_mp));
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("upd_index", 32'(upd_index), 32'(e_idx));
    chk("upd_hist", 32'(upd_hist), 32'(e_hist));
    chk("upd_taken", 32'(upd_taken), 32'(e_tk));
  endtask

  task automatic cycle();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  task automatic drv(input bit p, input int idx, input int hist, input bit tk,
                     input bit r, input bit rt);
    reset = 0; en = 1;
    push = p; push_index = IWIDTH'(idx); push_hist = HWIDTH'(hist); push_taken = tk;
    resolve = r; resolve_taken = rt;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1; en = 1; push = 1; resolve = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1; en = 0; push = 0; push_index = '0; push_hist = '0; push_taken = 0;
    resolve = 0; resolve_taken = 0;
    do_reset();
    do_reset();

    // single push then correct resolve
    drv(1, 5, 4'b1010, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 1);
    chk("t1_idx", 32'(upd_index), 32'd5);
    chk("t1_hist", 32'(upd_hist), 32'b1010);
    chk("t1_valid", 32'(upd_valid), 32'd1);
    drv(0, 0, 0, 0, 0, 0);

    // fill, overflow push dropped, drain in order across pointer wrap
    for (int k = 1; k <= 4; k++) drv(1, k, k, 1, 0, 0);
    chk("t2_full", 32'(full), 32'd1);
    drv(1, 9, 9, 1, 0, 0);
    chk("t2_cnt", 32'(count), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      drv(0, 0, 0, 0, 1, 1);
      chk("t2_seq", 32'(upd_index), 32'(k));
    end

    // mispredict flushes younger entries
    drv(1, 1, 1, 1, 0, 0);
    drv(1, 2, 2, 0, 0, 0);
    drv(1, 3, 3, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 0);
    chk("t3_mp", 32'(mispredict), 32'd1);
    chk("t3_cnt", 32'(count), 32'd0);
    drv(1, 6, 6, 1, 0, 0);
    drv(1, 8, 8, 1, 1, 1);
    chk("t3_new", 32'(upd_index), 32'd6);
    drv(0, 0, 0, 0, 1, 1);

    // push+correct resolve at full and at count==1
    for (int k = 10; k <= 13; k++) drv(1, k, k, 1, 0, 0);
    drv(1, 7, 7, 1, 1, 1);
    chk("t4_cnt", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) drv(0, 0, 0, 0, 1, 1);
    chk("t4_last", 32'(upd_index), 32'd7);
    drv(1, 20, 2, 0, 0, 0);
    drv(1, 21, 3, 0, 1, 0);
    chk("t4_one", 32'(count), 32'd1);
    drv(0, 0, 0, 0, 1, 0);

    // underflow sticky, enable gating, mid-stream reset
    drv(0, 0, 0, 0, 1, 1);
    chk("t5_uf", 32'(underflow), 32'd1);
    for (int k = 0; k < 3; k++) drv(1, 30 + k, k, 1, 0, 0);
    en = 0;
    for (int k = 0; k < 2; k++) begin
      push = k[0]; resolve = ~k[0]; resolve_taken = k[0]; push_index = 6'd40;
      cycle();
    end
    chk("t6_cnt", 32'(count), 32'd3);
    do_reset();
    chk("t6_uf", 32'(underflow), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      push = ($urandom_range(0, 9) < 6);
      push_index = IWIDTH'($urandom);
      push_hist = HWIDTH'($urandom);
      push_taken = 1'($urandom);
      resolve = ($urandom_range(0, 9) < 5);
      if (q.size() > 0 && $urandom_range(0, 9) < 8) resolve_taken = q[0].taken;
      else resolve_taken = 1'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
